// File: rtl/main_fsm.sv
// main_fsm: multicycle RISC-V control unit, Moore FSM.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset; forces FETCH immediately
//   op[6:0]     opcode from the instruction register
//   zero        ALU zero flag; only affects pc_write in BEQ
//   mem_ready   memory access complete (only used with MAIN_FSM_MEM_READY_EN)
//   pc_write, adr_src, ir_write, mem_write, reg_write, illegal   1-bit controls
//   result_src, alu_src_a, alu_src_b, alu_op                      2-bit selects
//                                  (alu_op: 00 add, 01 sub, 10 funct-decoded)
//   state[3:0]  current state encoding, for debug
//
// Build option: define MAIN_FSM_MEM_READY_EN to make FETCH, MEMREAD and
// MEMWRITE wait for mem_ready. The write enables of a stalled access fire
// only in the mem_ready cycle. Without the macro, mem_ready is ignored.
module main_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       illegal,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  state_t cur, nxt;
  logic   pc_update;
  logic   branch;
  logic   mem_go;  // memory-side handshake: high when a memory state may complete

`ifdef MAIN_FSM_MEM_READY_EN
  assign mem_go = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_go           = 1'b1;
`endif

  assign state = cur;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur <= S_FETCH;
    else       cur <= nxt;
  end

  // Next-state logic; op is only consulted when leaving DECODE or MEMADR
  always_comb begin
    nxt = cur;
    case (cur)
      S_FETCH:    if (mem_go) nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_R:         nxt = S_EXECR;
          OP_I:         nxt = S_EXECI;
          OP_JAL:       nxt = S_JAL;
          OP_BEQ:       nxt = S_BEQ;
          default:      nxt = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   nxt = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_go) nxt = S_MEMWB;
      S_MEMWB:    nxt = S_FETCH;
      S_MEMWRITE: if (mem_go) nxt = S_FETCH;
      S_EXECR:    nxt = S_ALUWB;
      S_EXECI:    nxt = S_ALUWB;
      S_ALUWB:    nxt = S_FETCH;
      S_JAL:      nxt = S_ALUWB;
      S_BEQ:      nxt = S_FETCH;
      S_ILLEGAL:  nxt = S_ILLEGAL;
      default:    nxt = S_FETCH;  // unused encodings recover to FETCH
    endcase
  end

  // Output logic: Moore outputs, except pc_write which also sees zero
  always_comb begin
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    case (cur)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_go;
        pc_update  = mem_go;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = mem_go;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_ALUWB:    reg_write = 1'b1;
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      S_ILLEGAL:  illegal = 1'b1;
      default: ;
    endcase
    pc_write = pc_update | (branch & zero);
    // The state is already FETCH during reset, so the selects are correct;
    // only the enables need to be suppressed.
    if (reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
    end
  end

endmodule

// File: doc/main_fsm.md
MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port op, input, 7 bits: opcode from the instruction register.
REQ-005 The block SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-006 The block SHALL have port mem_ready, input, 1 bit: memory access complete; used only when MEM_READY_EN is defined.
REQ-007 The block SHALL have these outputs, 1 bit each: pc_write, adr_src, ir_write, mem_write, reg_write, illegal.
REQ-008 The block SHALL have these outputs, 2 bits each: result_src, alu_src_a, alu_src_b, alu_op. alu_op feeds the ALU decoder (00 add, 01 sub, 10 funct-decoded).
REQ-009 The block SHALL have port state, output, 4 bits: current state encoding, for debug.

Function
REQ-010 The block SHALL be a Moore FSM with the following states and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, JAL=9, BEQ=10, ILLEGAL=11.
REQ-011 The FSM SHALL make these transitions:
- FETCH->DECODE.
- DECODE, selected by op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1101111 -> JAL; 1100011 -> BEQ; any other op -> ILLEGAL.
REQ-012 From MEMADR, the FSM SHALL go to MEMREAD if op=0000011 and to MEMWRITE otherwise.
REQ-013 The FSM SHALL make these further transitions:
- MEMREAD->MEMWB.
- MEMWB, MEMWRITE, ALUWB and BEQ -> FETCH.
- EXECR, EXECI and JAL -> ALUWB.
- ILLEGAL->ILLEGAL (sticky).
REQ-014 Each state SHALL drive these non-default outputs (fields: alu_src_a / alu_src_b / alu_op / result_src):
- FETCH: 00/10/00/10; ir_write=1, pc_update=1.
- DECODE: 01/01/00.
- MEMADR: 10/01/00.
- MEMREAD: result_src=00, adr_src=1.
- MEMWB: result_src=01, reg_write=1.
- MEMWRITE: result_src=00, adr_src=1, mem_write=1.
- EXECR: 10/00/10.
- EXECI: 10/01/10.
- ALUWB: result_src=00, reg_write=1.
- JAL: 01/10/00; result_src=00, pc_update=1.
- BEQ: 10/00/01; result_src=00, branch=1.
- ILLEGAL: illegal=1, all enables 0.
REQ-015 Any output not listed for a state SHALL be 0.
REQ-016 The outputs SHALL be combinational from state only, with pc_write = pc_update | (branch & zero) as the single exception.
REQ-017 op SHALL be sampled only at the clock edge leaving DECODE or MEMADR; op changes in other states SHALL have no effect.
REQ-018 Instruction latency without stalls SHALL be: lw 5 cycles; sw, R-type, I-type and jal 4 cycles; beq 3 cycles.

Reset
REQ-019 Asserting reset SHALL force the state to FETCH immediately, without waiting for a clock edge, including from ILLEGAL.
REQ-020 While reset is high, pc_write, ir_write, mem_write, reg_write and illegal SHALL be held at 0.
REQ-021 While reset is high, the mux selects SHALL hold their FETCH values: alu_src_b=10, result_src=10, all others 00.
REQ-022 On the first rising clock edge after reset deasserts, the FSM SHALL perform a FETCH cycle with full enables.
REQ-023 Reset asserted mid-instruction SHALL abandon that instruction with no further write enables.

Configuration
REQ-024 The block SHALL support a macro MAIN_FSM_MEM_READY_EN.
REQ-025 When MAIN_FSM_MEM_READY_EN is defined, FETCH, MEMREAD and MEMWRITE SHALL hold their state and outputs until mem_ready=1 is sampled.
REQ-026 When MAIN_FSM_MEM_READY_EN is defined, ir_write and pc_write in FETCH, and mem_write in MEMWRITE, SHALL assert only in the cycle where mem_ready=1, so each stalled access writes exactly once.
REQ-027 When MAIN_FSM_MEM_READY_EN is not defined, mem_ready SHALL be ignored and every state SHALL last one cycle.

Verification
REQ-028 The bench SHALL cover reset and a lw: after reset release with op=0000011, state SHALL go 0,1,2,3,4,0; reg_write=1 only in state 4, with result_src=01.
REQ-029 The bench SHALL cover beq: with op=1100011 and zero=1 in BEQ, pc_write=1 and alu_op=01. With zero=0, pc_write=0. In both cases the next state SHALL be FETCH.
REQ-030 The bench SHALL cover an R-type: with op=0110011, EXECR SHALL drive alu_op=10 and alu_src_a=10, then ALUWB SHALL drive reg_write=1, for 4 cycles total.
REQ-031 The bench SHALL cover an illegal opcode: with op=1111111 in DECODE, state SHALL become 11, illegal=1 and stay there for 10 cycles. Asserting reset mid-cycle SHALL give state=0 and illegal=0 immediately.
REQ-032 The bench SHALL cover stalls with MAIN_FSM_MEM_READY_EN defined: for sw with mem_ready held 0 for 3 cycles in MEMWRITE, state SHALL stay 5 and mem_write SHALL pulse exactly once, in the mem_ready=1 cycle.
REQ-033 The bench SHALL cover reset mid-instruction: asserting reset asynchronously during MEMWB SHALL give state=0 and reg_write=0 before the next clock edge.
